// File: rtl/tone_pkg.sv
// Shared encodings and default constants for the tone_sequencer block.
// The SUSTAIN state code only exists when TONE_SUSTAIN_EN is defined.
package tone_pkg;

  localparam int ADDR_W = 5;
  localparam int DIV_W  = 12;
  localparam int CNT_W  = 13;
  localparam int NKEY   = 4;

  localparam logic [DIV_W-1:0] DIV_C_DEF = 12'hBAA;
  localparam logic [DIV_W-1:0] DIV_D_DEF = 12'hA64;
  localparam logic [DIV_W-1:0] DIV_E_DEF = 12'h941;
  localparam logic [DIV_W-1:0] DIV_G_DEF = 12'h7C9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
`ifdef TONE_SUSTAIN_EN
    , SUSTAIN = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    NOTE_C = 2'd0,
    NOTE_D = 2'd1,
    NOTE_E = 2'd2,
    NOTE_G = 2'd3
  } note_t;

  typedef struct packed {
    logic  valid;
    note_t note;
  } req_t;

  // Last timer value of a step: 2*(div+1)-1 == {div, 1}.
  function automatic logic [CNT_W-1:0] step_term(input logic [DIV_W-1:0] div);
    return {div, 1'b1};
  endfunction

  // Fixed priority C > D > E > G over the debounced key set (bit 0 = C).
  function automatic req_t arbitrate(input logic [NKEY-1:0] keys);
    req_t r;
    r.valid = |keys;
    if (keys[0])      r.note = NOTE_C;
    else if (keys[1]) r.note = NOTE_D;
    else if (keys[2]) r.note = NOTE_E;
    else if (keys[3]) r.note = NOTE_G;
    else              r.note = NOTE_C;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one raw key.
// The debounced bit flips in the cycle the synchronised value has disagreed with it for DEB_CYCLES cycles.
module key_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk50Mghz,
  input  logic rst,
  input  logic key,
  output logic deb
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk50Mghz or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      // Any return to the current debounced level restarts the stability window.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Sine-ROM tone controller: debounced, priority-arbitrated keys drive a step timer and ROM address;
// note changes land only on period wraps. Optional TONE_SUSTAIN_EN adds a SUSTAIN tail after release.
module tone_sequencer #(
  parameter int          ADDR_W     = tone_pkg::ADDR_W,
  parameter int          DEB_CYCLES = 1000,
  parameter logic [11:0] DIV_C      = tone_pkg::DIV_C_DEF,
  parameter logic [11:0] DIV_D      = tone_pkg::DIV_D_DEF,
  parameter logic [11:0] DIV_E      = tone_pkg::DIV_E_DEF,
  parameter logic [11:0] DIV_G      = tone_pkg::DIV_G_DEF
`ifdef TONE_SUSTAIN_EN
  , parameter int        SUSTAIN_PERIODS = 4
`endif
) (
  input  logic              clk50Mghz,
  input  logic              rst,
  input  logic              key_c,
  input  logic              key_d,
  input  logic              key_e,
  input  logic              key_g,
  output logic [ADDR_W-1:0] address,
  output logic              active,
  output logic [1:0]        note,
  output logic              step
);
  import tone_pkg::*;

  logic [NKEY-1:0] key_raw, key_deb;
  req_t            req;

  assign key_raw = {key_g, key_e, key_d, key_c};

  genvar i;
  generate
    for (i = 0; i < NKEY; i++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk50Mghz (clk50Mghz),
        .rst       (rst),
        .key       (key_raw[i]),
        .deb       (key_deb[i])
      );
    end
  endgenerate

  assign req = arbitrate(key_deb);

  state_t             state, state_nxt;
  note_t              note_q;
  logic               load_note;
  logic [CNT_W-1:0]   tmr, term;
  logic [DIV_W-1:0]   div_sel;
  logic [ADDR_W-1:0]  addr_q;
  logic               tick, wrap;

`ifdef TONE_SUSTAIN_EN
  localparam int SUS_W = (SUSTAIN_PERIODS < 2) ? 1 : $clog2(SUSTAIN_PERIODS + 1);
  logic [SUS_W-1:0] sus_cnt;
`endif

  always_comb begin
    div_sel = DIV_C;
    case (note_q)
      NOTE_C: div_sel = DIV_C;
      NOTE_D: div_sel = DIV_D;
      NOTE_E: div_sel = DIV_E;
      NOTE_G: div_sel = DIV_G;
      default: div_sel = DIV_C;
    endcase
  end

  assign term = step_term(div_sel);
  assign tick = (state != IDLE) && (tmr == term);
  assign wrap = tick && (addr_q == '1);

  always_ff @(posedge clk50Mghz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_note = 1'b0;
    case (state)
      IDLE: begin
        if (req.valid) begin
          state_nxt = PLAY;
          load_note = 1'b1;
        end
      end
      PLAY: begin
        if (!req.valid || req.note != note_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The wrap step is the only point where the note may change or sound may stop.
        if (wrap) begin
          if (req.valid) begin
            state_nxt = PLAY;
            load_note = 1'b1;
          end else begin
`ifdef TONE_SUSTAIN_EN
            state_nxt = SUSTAIN;
`else
            state_nxt = IDLE;
`endif
          end
        end else if (req.valid && req.note == note_q) begin
          state_nxt = PLAY;
        end
      end
`ifdef TONE_SUSTAIN_EN
      SUSTAIN: begin
        if (wrap) begin
          if (req.valid) begin
            state_nxt = PLAY;
            load_note = 1'b1;
          end else if (sus_cnt == SUS_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active = (state != IDLE);
    step   = tick;
  end

  // Timer restarts on every step, so a note switched at the wrap gets a full first interval.
  always_ff @(posedge clk50Mghz or posedge rst) begin
    if (rst) begin
      note_q <= NOTE_C;
      tmr    <= '0;
      addr_q <= '0;
    end else begin
      if (load_note) note_q <= req.note;
      if (state == IDLE || tick) tmr <= '0;
      else                       tmr <= tmr + 1'b1;
      if (state == IDLE) addr_q <= '0;
      else if (tick)     addr_q <= addr_q + 1'b1;
    end
  end

`ifdef TONE_SUSTAIN_EN
  always_ff @(posedge clk50Mghz or posedge rst) begin
    if (rst) begin
      sus_cnt <= '0;
    end else if (state == DRAIN && wrap && !req.valid) begin
      sus_cnt <= SUS_W'(SUSTAIN_PERIODS);
    end else if (state == SUSTAIN && wrap) begin
      sus_cnt <= sus_cnt - 1'b1;
    end
  end
`endif

  assign address = addr_q;
  assign note    = note_q;

endmodule
